// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: types shared by the multiplier scheduler
// and its pipelined multiplier.
package mul_sched_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int N_REQ_MAX = 8;
    localparam int TAG_BITS  = $clog2(N_REQ_MAX);

    typedef logic [TAG_BITS-1:0] tag_t;

    typedef struct packed {
        logic                 v;
        tag_t                 tag;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
    } stage_t;

    function automatic logic [N_REQ_MAX-1:0] onehot(
        input tag_t idx
    );
        return N_REQ_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/mul_sched_pipe.sv
// mul_pipe: registered unsigned multiplier with a parallel
// valid/tag shift register; drop-in for a vendor multiplier.
module mul_pipe
    import mul_sched_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LATENCY = 4,
    parameter int TAG_W   = TAG_BITS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               v_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               v_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [2*WIDTH-1:0] p_o
);

    localparam int PW = 2 * WIDTH;

    logic [LATENCY-1:0] v_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [PW-1:0]      p_q   [LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
        end else begin
            v_q[0] <= v_i;
            for (int k = 1; k < LATENCY; k++) begin
                v_q[k] <= v_q[k-1];
            end
        end
    end

    // Data path carries no reset; only v qualifies it.
    always_ff @(posedge clk_i) begin
        p_q[0]   <= PW'(a_i) * PW'(b_i);
        tag_q[0] <= tag_i;
        for (int k = 1; k < LATENCY; k++) begin
            p_q[k]   <= p_q[k-1];
            tag_q[k] <= tag_q[k-1];
        end
    end

    assign v_o   = v_q[LATENCY-1];
    assign tag_o = tag_q[LATENCY-1];
    assign p_o   = p_q[LATENCY-1];

endmodule

// File: rtl/mul_sched.sv
// mul_sched: round-robin sharing of one pipelined multiplier,
// returning each tagged product to its requester.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LATENCY = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         hold_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ*WIDTH-1:0]       req_a_i,
    input  logic [N_REQ*WIDTH-1:0]       req_b_i,
    output logic [N_REQ-1:0]             rsp_valid_o,
    output logic [2*WIDTH-1:0]           rsp_p_o,
    output logic [$clog2(LATENCY+1)-1:0] inflight_o,
    output logic                         busy_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int IW    = $clog2(LATENCY+1);

    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [IW-1:0]      infl_q, infl_d;
    logic [N_REQ-1:0]   rsp_v_q, rsp_v_d;
    logic [2*WIDTH-1:0] rsp_p_q, rsp_p_d;

    logic               found;
    logic               issue;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   idx;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               pv;
    tag_t               ptag;
    logic [2*WIDTH-1:0] pp;

    // First valid requester at or after rr_q, wrapping.
    always_comb begin : arb
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(rr_q) + k) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign issue = found & ~hold_i & ~rst_i;

    always_comb begin : grant
        req_ready_o = '0;
        if (issue) begin
            req_ready_o = N_REQ'(onehot(tag_t'(gidx)));
        end
    end

    always_comb begin : opmux
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx == PTR_W'(i)) begin
                a_sel = req_a_i[i*WIDTH +: WIDTH];
                b_sel = req_b_i[i*WIDTH +: WIDTH];
            end
        end
    end

    mul_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .TAG_W   (TAG_BITS)
    ) u_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .v_i   (issue),
        .tag_i (tag_t'(gidx)),
        .a_i   (a_sel),
        .b_i   (b_sel),
        .v_o   (pv),
        .tag_o (ptag),
        .p_o   (pp)
    );

    always_comb begin : nxt
        rr_d    = rr_q;
        infl_d  = infl_q;
        rsp_v_d = '0;
        rsp_p_d = rsp_p_q;
        if (issue) begin
            rr_d = (gidx == PTR_W'(N_REQ-1)) ?
                   '0 : gidx + PTR_W'(1);
        end
        unique case ({issue, pv})
            2'b10:   infl_d = infl_q + IW'(1);
            2'b01:   infl_d = infl_q - IW'(1);
            default: infl_d = infl_q;
        endcase
        if (pv) begin
            rsp_v_d = N_REQ'(onehot(ptag));
            rsp_p_d = pp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= '0;
            infl_q  <= '0;
            rsp_v_q <= '0;
            rsp_p_q <= '0;
        end else begin
            rr_q    <= rr_d;
            infl_q  <= infl_d;
            rsp_v_q <= rsp_v_d;
            rsp_p_q <= rsp_p_d;
        end
    end

    assign rsp_valid_o = rsp_v_q;
    assign rsp_p_o     = rsp_p_q;
    assign inflight_o  = infl_q;
    assign busy_o      = (infl_q != '0) | (|req_valid_i);

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed steps plus a random phase against
// an independent arbiter/scoreboard model.
module tb_mul_sched;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 4;

    typedef struct {
        int          tag;
        logic [63:0] p;
        int          due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [2*W-1:0] rsp_p;
    logic [2:0]     inflight;
    logic           busy;

    int   errors = 0;
    int   checks = 0;
    int   g, j, ptr, mw;
    int   wait_n [N];
    exp_t q [$];
    exp_t e;
    logic [N-1:0] expg;

    mul_sched #(
        .N_REQ   (N),
        .WIDTH   (W),
        .LATENCY (L)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .hold_i      (hold),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_p_o     (rsp_p),
        .inflight_o  (inflight),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, want 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setop(input int i,
                         input logic [31:0] a,
                         input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        setop(0, 32'd3, 32'd5);

        // reset state
        repeat (3) tick();
        settle();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_rspv", 64'(rsp_valid), 64'h0);
        check("rst_rspp", rsp_p, 64'h0);
        check("rst_infl", 64'(inflight), 64'h0);
        rst       = 1'b0;
        req_valid = '0;
        settle();
        check("idle_busy", 64'(busy), 64'h0);
        repeat (5) tick();

        // test 1: single issue 3*5
        req_valid = 4'b0001;
        settle();
        check("t1_ready", 64'(req_ready), 64'h1);
        check("t1_busy", 64'(busy), 64'h1);
        tick();
        req_valid = '0;
        check("t1_infl1", 64'(inflight), 64'h1);
        repeat (3) tick();
        check("t1_early", 64'(rsp_valid), 64'h0);
        tick();
        check("t1_rspv", 64'(rsp_valid), 64'h1);
        check("t1_rspp", rsp_p, 64'd15);
        check("t1_infl0", 64'(inflight), 64'h0);
        tick();
        check("t1_pulse", 64'(rsp_valid), 64'h0);
        check("t1_holdp", rsp_p, 64'd15);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // test 2: all valid, round robin
        for (int i = 0; i < N; i++)
            setop(i, 32'(i + 1), 32'h10);
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            settle();
            check("t2_ready", 64'(req_ready),
                  (c < 8) ? 64'(1 << (c % 4)) : 64'h0);
            tick();
            if (c >= 4) begin
                check("t2_rspv", 64'(rsp_valid),
                      64'(1 << ((c - 4) % 4)));
                check("t2_rspp", rsp_p,
                      64'(((c - 4) % 4 + 1) * 16));
            end
            if (c == 5)
                check("t2_inflmax", 64'(inflight), 64'd4);
        end
        check("t2_infl0", 64'(inflight), 64'h0);

        // test 3: max operands, then zero
        setop(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b1000;
        settle();
        check("t3_rdy3", 64'(req_ready), 64'h8);
        tick();
        setop(0, 32'h0, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        settle();
        check("t3_rdy0", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("t3_rspv3", 64'(rsp_valid), 64'h8);
        check("t3_max", rsp_p, 64'hFFFF_FFFE_0000_0001);
        tick();
        check("t3_rspv0", 64'(rsp_valid), 64'h1);
        check("t3_zero", rsp_p, 64'h0);

        // test 4: hold with two ops in flight
        for (int i = 0; i < N; i++)
            setop(i, 32'(i + 1), 32'h10);
        req_valid = 4'hF;
        settle();
        check("t4_rdy1", 64'(req_ready), 64'h2);
        tick();
        settle();
        check("t4_rdy2", 64'(req_ready), 64'h4);
        tick();
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            settle();
            check("t4_hold", 64'(req_ready), 64'h0);
            tick();
            if (h == 0)
                check("t4_infl2", 64'(inflight), 64'd2);
            if (h == 2) begin
                check("t4_rspv1", 64'(rsp_valid), 64'h2);
                check("t4_rspp1", rsp_p, 64'h20);
            end
        end
        hold = 1'b0;
        settle();
        check("t4_resume", 64'(req_ready), 64'h8);
        tick();
        check("t4_rspv2", 64'(rsp_valid), 64'h4);
        check("t4_rspp2", rsp_p, 64'h30);
        check("t4_infl1", 64'(inflight), 64'd1);
        req_valid = '0;
        repeat (4) tick();
        check("t4_rspv3", 64'(rsp_valid), 64'h8);
        check("t4_rspp3", rsp_p, 64'h40);
        check("t4_infl0", 64'(inflight), 64'h0);

        // test 5: reset discards in-flight ops
        req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("t5_ready", 64'(req_ready), 64'(1 << k));
            tick();
        end
        req_valid = '0;
        tick();
        rst       = 1'b1;
        req_valid = 4'b1100;
        settle();
        check("t5_rstrdy", 64'(req_ready), 64'h0);
        tick();
        check("t5_rspv_a", 64'(rsp_valid), 64'h0);
        tick();
        check("t5_rspv_b", 64'(rsp_valid), 64'h0);
        check("t5_rspp", rsp_p, 64'h0);
        check("t5_infl", 64'(inflight), 64'h0);
        rst = 1'b0;
        settle();
        check("t5_lowest", 64'(req_ready), 64'h4);
        tick();
        check("t5_rspv_c", 64'(rsp_valid), 64'h0);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_noresp", 64'(rsp_valid), 64'h0);
        end
        tick();
        check("t5_newv", 64'(rsp_valid), 64'h4);
        check("t5_newp", rsp_p, 64'h30);

        // test 6: random traffic vs model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ptr = 0;
        mw  = 0;
        for (int i = 0; i < N; i++) wait_n[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            req_valid = (c < 9990) ? N'($urandom) : '0;
            hold = (c < 9990) &&
                   ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++)
                setop(i, $urandom, $urandom);
            settle();
            g = -1;
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr + k) % N;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            expg = (g < 0) ? '0 : N'(1) << g;
            check("rnd_ready", 64'(req_ready), 64'(expg));
            if (g >= 0) begin
                e.tag = g;
                e.p   = {32'h0, req_a[g*W +: W]} *
                        {32'h0, req_b[g*W +: W]};
                e.due = c + L;
                q.push_back(e);
                ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == g)
                    wait_n[i] = 0;
                else if (g >= 0)
                    wait_n[i]++;
                if (wait_n[i] > mw) mw = wait_n[i];
            end
            tick();
            if (q.size() > 0 && q[0].due == c) begin
                check("rnd_rspv", 64'(rsp_valid),
                      64'(1 << q[0].tag));
                check("rnd_rspp", rsp_p, q[0].p);
                void'(q.pop_front());
            end else begin
                check("rnd_idle", 64'(rsp_valid), 64'h0);
            end
            check("rnd_infl", 64'(inflight), 64'(q.size()));
        end
        check("rnd_drain", 64'(q.size()), 64'h0);
        check("rnd_fair", 64'(mw <= N - 1), 64'h1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
